// File: rtl/alu_responder.sv
// rtl/alu_responder.sv - start/ack handshaked ALU with iterative multiply and optional divide (ALU_RESPONDER_DIV_EN)
module alu_responder #(
  parameter int DATA_W   = 32,
  parameter int OP_W     = 4,
  parameter int CSRIN_W  = 2,
  parameter int CSROUT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   OP1,
  input  logic [DATA_W-1:0]   OP2,
  input  logic [OP_W-1:0]     ALUOP,
  input  logic [CSRIN_W-1:0]  CSR_ALU_IN,
  output logic [DATA_W-1:0]   OP3,
  output logic [CSROUT_W-1:0] CSR_ALU_OUT
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SLL   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SRL   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SRA   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_MUL   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_MULHU = OP_W'(9);
`ifdef ALU_RESPONDER_DIV_EN
  localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(10);
  localparam logic [OP_W-1:0] OP_REMU  = OP_W'(11);
`endif

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t                state, state_nxt;
  logic                  start, ack;
  logic [DATA_W-1:0]     op_a;
  logic [OP_W-1:0]       op_code;
  logic [2*DATA_W-1:0]   prod, prod_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_W-1:0]     res_q;
  logic [3:0]            flags;  // {err, overflow, carry, zero}
  logic                  is_mul_in, is_iter;
  logic [DATA_W-1:0]     alu_res, fin_res;
  logic                  alu_c, alu_v, alu_err, fin_v;
  logic [DATA_W:0]       add_w, sub_w;
  logic [4:0]            shamt;
  logic [DATA_W:0]       mul_sum;
`ifdef ALU_RESPONDER_DIV_EN
  logic [DATA_W-1:0]     op_b;
  logic [DATA_W:0]       div_shl;
  logic [2*DATA_W-1:0]   div_nxt;
`endif

  assign start = CSR_ALU_IN[0];
  assign ack   = CSR_ALU_IN[1];
  assign shamt = OP2[4:0];

  // Single-cycle results and flags, evaluated on the live inputs at acceptance
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    add_w   = {1'b0, OP1} + {1'b0, OP2};
    sub_w   = {1'b0, OP1} - {1'b0, OP2};
    case (ALUOP)
      OP_ADD: begin
        alu_res = add_w[DATA_W-1:0];
        alu_c   = add_w[DATA_W];
        alu_v   = (OP1[DATA_W-1] == OP2[DATA_W-1]) && (add_w[DATA_W-1] != OP1[DATA_W-1]);
      end
      OP_SUB: begin
        alu_res = sub_w[DATA_W-1:0];
        alu_c   = sub_w[DATA_W];
        alu_v   = (OP1[DATA_W-1] != OP2[DATA_W-1]) && (sub_w[DATA_W-1] != OP1[DATA_W-1]);
      end
      OP_AND:   alu_res = OP1 & OP2;
      OP_OR:    alu_res = OP1 | OP2;
      OP_XOR:   alu_res = OP1 ^ OP2;
      OP_SLL:   alu_res = OP1 << shamt;
      OP_SRL:   alu_res = OP1 >> shamt;
      OP_SRA:   alu_res = $unsigned($signed(OP1) >>> shamt);
      OP_MUL, OP_MULHU: alu_res = '0;
`ifdef ALU_RESPONDER_DIV_EN
      // Only reached as a single-cycle result when the divisor is zero
      OP_DIVU: begin
        alu_res = '1;
        alu_err = 1'b1;
      end
      OP_REMU: begin
        alu_res = OP1;
        alu_err = 1'b1;
      end
`endif
      default:  alu_err = 1'b1;
    endcase
  end

  // Decide whether the accepted operation needs the bit-serial datapath
  always_comb begin
    is_mul_in = (ALUOP == OP_MUL) || (ALUOP == OP_MULHU);
    is_iter   = is_mul_in;
`ifdef ALU_RESPONDER_DIV_EN
    if (((ALUOP == OP_DIVU) || (ALUOP == OP_REMU)) && (OP2 != '0))
      is_iter = 1'b1;
`endif
  end

  // One shift-add or restoring-divide step; prod holds {hi/remainder, lo/quotient}
  always_comb begin
    mul_sum  = {1'b0, prod[2*DATA_W-1:DATA_W]} + (prod[0] ? {1'b0, op_a} : '0);
    prod_nxt = {mul_sum, prod[DATA_W-1:1]};
`ifdef ALU_RESPONDER_DIV_EN
    div_shl = {prod[2*DATA_W-1:DATA_W], prod[DATA_W-1]};
    if (div_shl >= {1'b0, op_b})
      div_nxt = {div_shl[DATA_W-1:0] - op_b, prod[DATA_W-2:0], 1'b1};
    else
      div_nxt = {div_shl[DATA_W-1:0], prod[DATA_W-2:0], 1'b0};
    if ((op_code == OP_DIVU) || (op_code == OP_REMU))
      prod_nxt = div_nxt;
`endif
    fin_res = (op_code == OP_MUL) ? prod_nxt[DATA_W-1:0] : prod_nxt[2*DATA_W-1:DATA_W];
`ifdef ALU_RESPONDER_DIV_EN
    if (op_code == OP_DIVU)
      fin_res = prod_nxt[DATA_W-1:0];
`endif
    fin_v = (op_code == OP_MUL) && (prod_nxt[2*DATA_W-1:DATA_W] != '0);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; ack leaves DONE straight to IDLE so a coincident start is never seen
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = is_iter ? S_CALC : S_DONE;
      S_CALC: if (cnt == CNT_W'(DATA_W-1)) state_nxt = S_DONE;
      S_DONE: if (ack) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, iteration and result/flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_a    <= '0;
      op_code <= '0;
      prod    <= '0;
      cnt     <= '0;
      res_q   <= '0;
      flags   <= '0;
`ifdef ALU_RESPONDER_DIV_EN
      op_b    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (start) begin
          op_a    <= OP1;
          op_code <= ALUOP;
          cnt     <= '0;
          prod    <= is_mul_in ? {{DATA_W{1'b0}}, OP2} : {{DATA_W{1'b0}}, OP1};
`ifdef ALU_RESPONDER_DIV_EN
          op_b    <= OP2;
`endif
          if (!is_iter) begin
            res_q <= alu_res;
            flags <= {alu_err, alu_v, alu_c, alu_res == '0};
          end
        end
        S_CALC: begin
          prod <= prod_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_W'(DATA_W-1)) begin
            res_q <= fin_res;
            flags <= {1'b0, fin_v, 1'b0, fin_res == '0};
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode: busy/valid from state, flags from the result register
  always_comb begin
    OP3            = res_q;
    CSR_ALU_OUT    = '0;
    CSR_ALU_OUT[0] = (state != S_IDLE);
    CSR_ALU_OUT[1] = (state == S_DONE);
    CSR_ALU_OUT[5:2] = flags;
  end

endmodule

// File: tb/tb_alu_responder.sv
// tb/tb_alu_responder.sv - scoreboard bench for alu_responder
module tb_alu_responder;

  typedef struct {
    logic [31:0] res;
    logic        zero, carry, ovf, err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] op1 = '0, op2 = '0, op3;
  logic [3:0]  aluop = '0;
  logic [1:0]  csr_in = '0;
  logic [5:0]  csr_out;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        sb[$];

  alu_responder dut (
    .clk(clk), .rst(rst), .OP1(op1), .OP2(op2), .ALUOP(aluop),
    .CSR_ALU_IN(csr_in), .OP3(op3), .CSR_ALU_OUT(csr_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    logic [32:0] s;
    e.res = '0; e.carry = 0; e.ovf = 0; e.err = 0; e.lat = 1;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; e.res = s[31:0]; e.carry = s[32];
                  e.ovf = (a[31] == b[31]) && (e.res[31] != a[31]); end
      4'd1: begin e.res = a - b; e.carry = (a < b);
                  e.ovf = (a[31] != b[31]) && (e.res[31] != a[31]); end
      4'd2: e.res = a & b;
      4'd3: e.res = a | b;
      4'd4: e.res = a ^ b;
      4'd5: e.res = a << b[4:0];
      4'd6: e.res = a >> b[4:0];
      4'd7: e.res = $unsigned($signed(a) >>> b[4:0]);
      4'd8: begin e.res = p[31:0]; e.ovf = (p[63:32] != 0); e.lat = 33; end
      4'd9: begin e.res = p[63:32]; e.lat = 33; end
`ifdef ALU_RESPONDER_DIV_EN
      4'd10: if (b == 0) begin e.res = 32'hFFFF_FFFF; e.err = 1; end
             else begin e.res = a / b; e.lat = 33; end
      4'd11: if (b == 0) begin e.res = a; e.err = 1; end
             else begin e.res = a % b; e.lat = 33; end
`endif
      default: e.err = 1;
    endcase
    e.zero = (e.res == 0);
    return e;
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit poke, input int hold, input bit ack_start);
    exp_t e;
    int   lat;
    @(negedge clk);
    op1 = a; op2 = b; aluop = op; csr_in = 2'b01;
    sb.push_back(model(op, a, b));
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (poke && lat >= 3 && lat <= 5) begin
        csr_in = 2'b01; op1 = 32'h1234; op2 = 32'h5678; aluop = 4'd0;
      end else csr_in = 2'b00;
      if (csr_out[1]) break;
    end
    csr_in = 2'b00;
    e = sb.pop_front();
    check($sformatf("lat op%0d", op), 64'(lat), 64'(e.lat));
    repeat (hold) @(negedge clk);
    check($sformatf("res op%0d", op), 64'(op3), 64'(e.res));
    check($sformatf("flags op%0d", op), 64'(csr_out), 64'({e.err, e.ovf, e.carry, e.zero, 2'b11}));
    csr_in = ack_start ? 2'b11 : 2'b10;
    op1 = 32'd5; op2 = 32'd6; aluop = 4'd0;
    @(posedge clk);
    @(negedge clk);
    csr_in = 2'b00;
    check($sformatf("ack op%0d", op), 64'(csr_out[1:0]), 64'd0);
    if (ack_start) begin
      @(negedge clk);
      check("start with ack ignored", 64'(csr_out[1:0]), 64'd0);
    end
  endtask

  initial begin
    bit seen;
    repeat (3) @(negedge clk);
    check("reset OP3", 64'(op3), 64'd0);
    check("reset CSR", 64'(csr_out), 64'd0);
    rst = 1'b1;

    run_op(4'd0, 32'hFFFF_FFFF, 32'd1, 0, 0, 0);
    run_op(4'd1, 32'h8000_0000, 32'd1, 0, 0, 0);
    run_op(4'd0, 32'h7FFF_FFFF, 32'd1, 0, 0, 0);
    run_op(4'd1, 32'd3, 32'd5, 0, 0, 0);
    run_op(4'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 0, 0, 0);
    run_op(4'd3, 32'hF000_0000, 32'h0000_000F, 0, 0, 0);
    run_op(4'd4, 32'hAAAA_5555, 32'hAAAA_5555, 0, 0, 0);
    run_op(4'd5, 32'h0000_0003, 32'h0000_0025, 0, 0, 0);
    run_op(4'd6, 32'h8000_0000, 32'h0000_001F, 0, 0, 0);
    run_op(4'd7, 32'h8000_0010, 32'h0000_0004, 0, 0, 0);
    run_op(4'd8, 32'h0001_0000, 32'h0001_0000, 0, 0, 0);
    run_op(4'd9, 32'h0001_0000, 32'h0001_0000, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      run_op(4'd8, $urandom, $urandom, 0, 0, 0);
      run_op(4'd9, $urandom, $urandom, 0, 0, 0);
    end
    for (int i = 12; i < 16; i++) run_op(4'(i), 32'd9, 32'd9, 0, 0, 0);
    run_op(4'd10, 32'd100, 32'd7, 0, 0, 0);
    run_op(4'd11, 32'd100, 32'd7, 0, 0, 0);
    run_op(4'd10, 32'd5, 32'd0, 0, 0, 0);
    run_op(4'd11, 32'd5, 32'd0, 0, 0, 0);
    run_op(4'd10, 32'hFFFF_FFFF, 32'd3, 0, 0, 0);

    run_op(4'd8, 32'h0000_0123, 32'h0000_0456, 1, 10, 1);
    run_op(4'd0, 32'd20, 32'd22, 0, 10, 1);

    @(negedge clk);
    op1 = 32'hFFFF; op2 = 32'hFFFF; aluop = 4'd8; csr_in = 2'b01;
    @(posedge clk);
    @(negedge clk);
    csr_in = 2'b00;
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid-reset OP3", 64'(op3), 64'd0);
    check("mid-reset CSR", 64'(csr_out), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (csr_out[1]) seen = 1;
    end
    check("no valid after reset abort", 64'(seen), 64'd0);
    run_op(4'd4, 32'h1357_9BDF, 32'hFFFF_0000, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_responder.md
ALU_RESPONDER -- requirements
Module: alu_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 32: operand and result width.
REQ-002 SHALL have parameter OP_W, default 4: ALUOP width.
REQ-003 SHALL have parameter CSRIN_W, default 2, and CSROUT_W, default 6: control-in and status-out widths.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port OP1  in  DATA_W  operand A.
REQ-007 SHALL have port OP2  in  DATA_W  operand B.
REQ-008 SHALL have port ALUOP  in  OP_W  operation code.
REQ-009 SHALL have port CSR_ALU_IN  in  CSRIN_W  control bits: [0] start, [1] ack.
REQ-010 SHALL have port OP3  out  DATA_W  registered result.
REQ-011 SHALL have port CSR_ALU_OUT  out  CSROUT_W  status bits: [0] busy, [1] valid, [2] zero, [3] carry, [4] overflow, [5] err.

Function
REQ-012 SHALL use this opcode map: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 MUL (low word), 9 MULHU (high word, unsigned), 10 DIVU, 11 REMU.
REQ-013 SHALL treat opcodes 12-15 as illegal: OP3=0, err=1, single-cycle timing.
REQ-014 SHALL implement the FSM states IDLE, CALC and DONE.
REQ-015 SHALL latch OP1, OP2 and ALUOP in IDLE when start=1; inputs are ignored at all other times.
REQ-016 SHALL handle opcodes 0-7, illegal opcodes, and DIVU/REMU with OP2=0 as single-cycle: IDLE->DONE, valid=1 on the edge after acceptance.
REQ-017 SHALL handle MUL/MULHU by iterative shift-add, and DIVU/REMU by restoring division, one bit per cycle: IDLE->CALC, exactly DATA_W cycles in CALC, then DONE, so valid=1 DATA_W+1 edges after acceptance.
REQ-018 SHALL drive busy=1 in CALC and DONE, and busy=0 in IDLE.
REQ-019 SHALL hold OP3 and the flags stable in DONE until ack=1; on ack, valid returns to 0 and the FSM enters IDLE on the same edge.
REQ-020 SHALL NOT accept start in the DONE cycle in which ack is taken; a new operation is accepted no earlier than the next IDLE cycle.
REQ-021 SHALL set zero = (OP3==0), computed on the final result for every operation.
REQ-022 SHALL set carry to the unsigned carry-out for ADD and to the borrow for SUB; carry=0 otherwise.
REQ-023 SHALL set overflow to the signed overflow for ADD/SUB, and for MUL to (high word != 0); overflow=0 otherwise.
REQ-024 SHALL shift by OP2[4:0] only for SLL/SRL/SRA; SRA sign-extends.
REQ-025 SHALL handle divide by zero as: DIVU OP3=all ones, REMU OP3=OP1, err=1.
REQ-026 SHALL ignore start=1 while busy, with no effect on the in-flight operation.

Reset
REQ-027 SHALL, on rst=0 asynchronously, force the FSM to IDLE, OP3=0, CSR_ALU_OUT=0, and clear the iteration counter and internal operand registers.
REQ-028 SHALL abort any in-flight CALC on reset mid-operation, producing no valid pulse after release.
REQ-029 SHALL accept start on the first rising edge after rst deasserts.

Configuration
REQ-030 SHALL compile the DIVU/REMU datapath in only when macro ALU_RESPONDER_DIV_EN is defined.
REQ-031 SHALL, without ALU_RESPONDER_DIV_EN, treat opcodes 10-11 as illegal per REQ-013, with no divider logic present.

Verification
REQ-032 SHALL cover: ADD OP1=0xFFFFFFFF, OP2=1 -> valid 1 edge after start, OP3=0, zero=1, carry=1, overflow=0.
REQ-033 SHALL cover: SUB OP1=0x80000000, OP2=1 -> OP3=0x7FFFFFFF, overflow=1, carry=0.
REQ-034 SHALL cover: MUL OP1=0x00010000, OP2=0x00010000 -> valid 33 edges after start, OP3=0, zero=1, overflow=1; MULHU with same operands -> OP3=1.
REQ-035 SHALL cover, with ALU_RESPONDER_DIV_EN defined: DIVU 100/7 -> OP3=14 after 33 edges; REMU 100/7 -> OP3=2; DIVU 5/0 -> OP3=0xFFFFFFFF, err=1, valid after 1 edge.
REQ-036 SHALL cover: start during CALC and start with ack in DONE -> both ignored; with ack held 0 for 10 cycles, OP3 stays stable; rst pulled low at CALC cycle 5 -> all outputs 0 and no valid after release.
